// File: rtl/sd_access_arbiter.sv
// rtl/sd_access_arbiter.sv - two-requester round-robin arbiter in front of one SD sector engine
module sd_access_arbiter #(
    parameter int          ADDR_W      = 32,
    parameter int          DATA_W      = 16,
    parameter logic [23:0] TIMEOUT_CYC = 24'd10_000_000
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              init_end,

    input  logic              r0_req,
    input  logic              r0_wr,
    input  logic [ADDR_W-1:0] r0_addr,
    output logic              r0_grant,
    output logic              r0_done,
    output logic              r0_err,
    input  logic [DATA_W-1:0] r0_wr_data,
    output logic              r0_wr_req,
    output logic              r0_rd_en,
    output logic [DATA_W-1:0] r0_rd_data,

    input  logic              r1_req,
    input  logic              r1_wr,
    input  logic [ADDR_W-1:0] r1_addr,
    output logic              r1_grant,
    output logic              r1_done,
    output logic              r1_err,
    input  logic [DATA_W-1:0] r1_wr_data,
    output logic              r1_wr_req,
    output logic              r1_rd_en,
    output logic [DATA_W-1:0] r1_rd_data,

    output logic              eng_start,
    output logic              eng_wr,
    output logic [ADDR_W-1:0] eng_addr,
    input  logic              eng_busy,
    input  logic              eng_done,
    output logic [DATA_W-1:0] eng_wr_data,
    input  logic              eng_wr_req,
    input  logic              eng_rd_en,
    input  logic [DATA_W-1:0] eng_rd_data
);

    typedef enum logic [1:0] {IDLE, START, RUN, RESP} state_t;

    state_t              state_q, state_d;
    logic [1:0]          grant_q, grant_d;
    logic [1:0]          done_q, done_d;
    logic [1:0]          err_q, err_d;
    logic                start_q, start_d;
    logic                wr_q, wr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                last_q, last_d;
    logic [23:0]         timer_q, timer_d;
    logic                winner;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        done_d  = 2'b00;
        err_d   = 2'b00;
        start_d = 1'b0;
        wr_d    = wr_q;
        addr_d  = addr_q;
        last_d  = last_q;
        timer_d = timer_q;
        // On a tie the requester that was not served last wins.
        winner  = (r0_req && r1_req) ? ~last_q : r1_req;

        case (state_q)
            IDLE: begin
                if (init_end && !eng_busy && (r0_req || r1_req)) begin
                    state_d = START;
                    grant_d = winner ? 2'b10 : 2'b01;
                    wr_d    = winner ? r1_wr : r0_wr;
                    addr_d  = winner ? r1_addr : r0_addr;
                    start_d = 1'b1;
                end
            end
            START: begin
                state_d = RUN;
                timer_d = '0;
            end
            RUN: begin
                if (eng_done) begin
                    state_d = RESP;
                    done_d  = grant_q;
                end else if (timer_q == TIMEOUT_CYC - 24'd1) begin
                    state_d = RESP;
                    done_d  = grant_q;
                    err_d   = grant_q;
                end else begin
                    timer_d = timer_q + 24'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
                grant_d = 2'b00;
                last_d  = grant_q[1];
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
            grant_q <= 2'b00;
            done_q  <= 2'b00;
            err_q   <= 2'b00;
            start_q <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            last_q  <= 1'b1;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            err_q   <= err_d;
            start_q <= start_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            last_q  <= last_d;
            timer_q <= timer_d;
        end
    end

    assign r0_grant  = grant_q[0];
    assign r1_grant  = grant_q[1];
    assign r0_done   = done_q[0];
    assign r1_done   = done_q[1];
    assign r0_err    = err_q[0];
    assign r1_err    = err_q[1];
    assign eng_start = start_q;
    assign eng_wr    = wr_q;
    assign eng_addr  = addr_q;

    // Data path follows the registered grant, so nothing leaks to a non-owner.
    assign eng_wr_data = grant_q[0] ? r0_wr_data : (grant_q[1] ? r1_wr_data : '0);
    assign r0_wr_req   = grant_q[0] & eng_wr_req;
    assign r1_wr_req   = grant_q[1] & eng_wr_req;
    assign r0_rd_en    = grant_q[0] & eng_rd_en;
    assign r1_rd_en    = grant_q[1] & eng_rd_en;
    assign r0_rd_data  = grant_q[0] ? eng_rd_data : '0;
    assign r1_rd_data  = grant_q[1] ? eng_rd_data : '0;

endmodule

// File: tb/tb_sd_access_arbiter.sv
// tb/tb_sd_access_arbiter.sv - self-checking bench for sd_access_arbiter
module tb_sd_access_arbiter;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        init_end = 1'b0;
    logic        r0_req = 1'b0, r0_wr = 1'b0, r1_req = 1'b0, r1_wr = 1'b0;
    logic [31:0] r0_addr = '0, r1_addr = '0;
    logic        r0_grant, r0_done, r0_err, r0_wr_req, r0_rd_en;
    logic        r1_grant, r1_done, r1_err, r1_wr_req, r1_rd_en;
    logic [15:0] r0_wr_data = '0, r1_wr_data = '0, r0_rd_data, r1_rd_data;
    logic        eng_start, eng_wr;
    logic [31:0] eng_addr;
    logic        eng_busy = 1'b0, eng_done = 1'b0, eng_wr_req = 1'b0, eng_rd_en = 1'b0;
    logic [15:0] eng_wr_data, eng_rd_data = '0;

    int tests = 0;
    int fails = 0;

    sd_access_arbiter #(.ADDR_W(32), .DATA_W(16), .TIMEOUT_CYC(24'd1000)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .init_end(init_end),
        .r0_req(r0_req), .r0_wr(r0_wr), .r0_addr(r0_addr), .r0_grant(r0_grant),
        .r0_done(r0_done), .r0_err(r0_err), .r0_wr_data(r0_wr_data), .r0_wr_req(r0_wr_req),
        .r0_rd_en(r0_rd_en), .r0_rd_data(r0_rd_data),
        .r1_req(r1_req), .r1_wr(r1_wr), .r1_addr(r1_addr), .r1_grant(r1_grant),
        .r1_done(r1_done), .r1_err(r1_err), .r1_wr_data(r1_wr_data), .r1_wr_req(r1_wr_req),
        .r1_rd_en(r1_rd_en), .r1_rd_data(r1_rd_data),
        .eng_start(eng_start), .eng_wr(eng_wr), .eng_addr(eng_addr), .eng_busy(eng_busy),
        .eng_done(eng_done), .eng_wr_data(eng_wr_data), .eng_wr_req(eng_wr_req),
        .eng_rd_en(eng_rd_en), .eng_rd_data(eng_rd_data)
    );

    always #10 sys_clk = ~sys_clk;

    always @(negedge sys_clk) begin
        if (sys_rst_n) begin
            tests++;
            if (r0_grant && r1_grant) begin
                fails++;
                $display("FAIL grant_exclusive: r0_grant=%0b r1_grant=%0b, required not both 1", r0_grant, r1_grant);
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        sys_rst_n = 1'b0;
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
    endtask

    // Engine stand-in: waits for eng_start, asserts eng_done k cycles after RUN entry, reports what it saw.
    task automatic do_op(input int k, output bit to, output int owner, output logic [31:0] addr,
                         output logic wr, output int lat, output logic [1:0] dmask, output logic [1:0] emask);
        bit seen = 1'b0;
        to = 1'b0; owner = -1; addr = '0; wr = 1'b0; lat = -1; dmask = 2'b00; emask = 2'b00;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge sys_clk);
            seen = eng_start;
        end
        if (!seen) begin
            to = 1'b1;
            return;
        end
        owner = r0_grant ? 0 : (r1_grant ? 1 : -1);
        addr  = eng_addr;
        wr    = eng_wr;
        @(posedge sys_clk);
        for (int i = 0; i < 3000 && lat < 0; i++) begin
            @(negedge sys_clk);
            if (r0_done || r1_done) begin
                lat = i;
                dmask = {r1_done, r0_done};
                emask = {r1_err, r0_err};
                eng_done = 1'b0;
            end else begin
                eng_done = (i == k);
            end
        end
        eng_done = 1'b0;
        if (lat < 0) to = 1'b1;
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        #1;
        tests++;
        if ({r0_grant, r1_grant, eng_start, eng_wr} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_ctrl: grant/start/wr=%b, required 0000", {r0_grant, r1_grant, eng_start, eng_wr});
        end
        tests++;
        if ({r0_done, r1_done, r0_err, r1_err} !== 4'b0000 || eng_addr !== 32'h0) begin
            fails++;
            $display("FAIL reset_resp: done/err=%b addr=%h, required 0000 / 0", {r0_done, r1_done, r0_err, r1_err}, eng_addr);
        end
        apply_reset();
    endtask

    task automatic test_init_gate();
        int bad = 0;
        init_end = 1'b0; r0_req = 1'b1; r0_addr = 32'h55; r0_wr = 1'b0;
        repeat (100) begin
            @(negedge sys_clk);
            if (r0_grant || r1_grant || eng_start) bad++;
        end
        tests++;
        if (bad !== 0) begin
            fails++;
            $display("FAIL init_gate: %0d cycles with grant/start, required 0", bad);
        end
        init_end = 1'b1; eng_busy = 1'b1; bad = 0;
        repeat (10) begin
            @(negedge sys_clk);
            if (r0_grant || eng_start) bad++;
        end
        tests++;
        if (bad !== 0) begin
            fails++;
            $display("FAIL busy_gate: %0d cycles with grant/start, required 0", bad);
        end
        eng_busy = 1'b0;
        @(negedge sys_clk);
        tests++;
        if ({r0_grant, eng_start} !== 2'b11) begin
            fails++;
            $display("FAIL init_grant: grant,start=%b, required 11", {r0_grant, eng_start});
        end
        r0_req = 1'b0;
        @(negedge sys_clk);
        tests++;
        if ({r0_grant, eng_start} !== 2'b10) begin
            fails++;
            $display("FAIL start_pulse: grant,start=%b, required 10", {r0_grant, eng_start});
        end
        eng_done = 1'b1;
        @(negedge sys_clk);
        eng_done = 1'b0;
        tests++;
        if ({r0_done, r0_err, r1_done} !== 3'b100) begin
            fails++;
            $display("FAIL init_done: done,err,r1_done=%b, required 100", {r0_done, r0_err, r1_done});
        end
        @(negedge sys_clk);
        tests++;
        if ({r0_done, r0_grant} !== 2'b00) begin
            fails++;
            $display("FAIL done_one_cycle: done,grant=%b, required 00", {r0_done, r0_grant});
        end
    endtask

    task automatic test_round_robin();
        int model_last = 1;
        int exp_owner, owner, lat;
        bit to;
        logic [31:0] addr;
        logic wr;
        logic [1:0] dm, em;
        apply_reset();
        r0_req = 1'b1; r1_req = 1'b1; r0_addr = 32'h10; r1_addr = 32'h20; r0_wr = 1'b0; r1_wr = 1'b0;
        for (int n = 0; n < 4; n++) begin
            exp_owner = (model_last == 1) ? 0 : 1;
            do_op(49, to, owner, addr, wr, lat, dm, em);
            tests++;
            if (to || owner !== exp_owner || addr !== (exp_owner == 1 ? 32'h20 : 32'h10)) begin
                fails++;
                $display("FAIL rr_grant%0d: to=%0b owner=%0d addr=%h, required owner %0d", n, to, owner, addr, exp_owner);
            end
            tests++;
            if (lat !== 50 || dm !== (exp_owner == 1 ? 2'b10 : 2'b01) || em !== 2'b00) begin
                fails++;
                $display("FAIL rr_done%0d: lat=%0d done=%b err=%b, required 50", n, lat, dm, em);
            end
            model_last = exp_owner;
        end
        r0_req = 1'b0; r1_req = 1'b0;
    endtask

    task automatic test_timeout();
        int owner, lat;
        bit to;
        logic [31:0] addr;
        logic wr;
        logic [1:0] dm, em;
        @(negedge sys_clk);
        r1_req = 1'b1; r1_wr = 1'b1; r1_addr = 32'h0000_0400;
        do_op(100000, to, owner, addr, wr, lat, dm, em);
        r1_req = 1'b0;
        tests++;
        if (to || owner !== 1 || wr !== 1'b1 || addr !== 32'h400) begin
            fails++;
            $display("FAIL to_cmd: to=%0b owner=%0d wr=%0b addr=%h, required 1/1/400", to, owner, wr, addr);
        end
        tests++;
        if (lat !== 1000 || dm !== 2'b10 || em !== 2'b10) begin
            fails++;
            $display("FAIL to_resp: lat=%0d done=%b err=%b, required 1000/10/10", lat, dm, em);
        end
    endtask

    task automatic test_done_vs_timeout();
        int owner, lat, bad;
        bit to;
        logic [31:0] addr;
        logic wr;
        logic [1:0] dm, em;
        r0_req = 1'b1; r0_addr = 32'h77;
        do_op(999, to, owner, addr, wr, lat, dm, em);
        r0_req = 1'b0;
        tests++;
        if (to || lat !== 1000 || dm !== 2'b01 || em !== 2'b00) begin
            fails++;
            $display("FAIL tie_done: to=%0b lat=%0d done=%b err=%b, required 1000/01/00", to, lat, dm, em);
        end
        repeat (2) @(negedge sys_clk);
        eng_done = 1'b1;
        @(negedge sys_clk);
        eng_done = 1'b0;
        bad = 0;
        repeat (5) begin
            @(negedge sys_clk);
            if (r0_done || r1_done || r0_grant || r1_grant) bad++;
        end
        tests++;
        if (bad !== 0) begin
            fails++;
            $display("FAIL stray_done: %0d cycles with done/grant, required 0", bad);
        end
    endtask

    task automatic test_routing();
        bit seen = 1'b0;
        bit got = 1'b0;
        r0_req = 1'b1; r0_wr_data = 16'h1234; r1_wr_data = 16'hBEEF;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge sys_clk);
            seen = eng_start;
        end
        r0_req = 1'b0;
        @(negedge sys_clk);
        eng_rd_en = 1'b1; eng_rd_data = 16'hA55A; eng_wr_req = 1'b1;
        #1;
        tests++;
        if (!seen || r0_rd_data !== 16'hA55A || r1_rd_data !== 16'h0 || r1_rd_en !== 1'b0 || r0_rd_en !== 1'b1) begin
            fails++;
            $display("FAIL route_rd: seen=%0b r0 %h/%0b r1 %h/%0b, required A55A/1 0000/0", seen, r0_rd_data, r0_rd_en, r1_rd_data, r1_rd_en);
        end
        tests++;
        if (eng_wr_data !== 16'h1234 || r0_wr_req !== 1'b1 || r1_wr_req !== 1'b0) begin
            fails++;
            $display("FAIL route_wr: data=%h r0_wr_req=%0b r1_wr_req=%0b, required 1234/1/0", eng_wr_data, r0_wr_req, r1_wr_req);
        end
        @(negedge sys_clk);
        eng_done = 1'b1;
        @(negedge sys_clk);
        eng_done = 1'b0;
        got = r0_done;
        @(negedge sys_clk);
        #1;
        tests++;
        if (!got || eng_wr_data !== 16'h0 || r0_rd_data !== 16'h0 || r0_rd_en !== 1'b0 || r0_wr_req !== 1'b0) begin
            fails++;
            $display("FAIL route_idle: done=%0b wr_data=%h rd_data=%h rd_en=%0b wr_req=%0b, required 1/0/0/0/0", got, eng_wr_data, r0_rd_data, r0_rd_en, r0_wr_req);
        end
        eng_rd_en = 1'b0; eng_wr_req = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        int owner, lat, bad;
        bit to;
        bit seen = 1'b0;
        logic [31:0] addr;
        logic wr;
        logic [1:0] dm, em;
        r0_req = 1'b1; r0_addr = 32'h10; r1_addr = 32'h20;
        do_op(3, to, owner, addr, wr, lat, dm, em);
        r0_req = 1'b0;
        @(negedge sys_clk);
        r0_req = 1'b1; r0_wr = 1'b1;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge sys_clk);
            seen = eng_start;
        end
        r0_req = 1'b0;
        repeat (10) @(negedge sys_clk);
        eng_rd_en = 1'b1; eng_rd_data = 16'hFFFF;
        #3 sys_rst_n = 1'b0;
        #1;
        tests++;
        if (!seen || {r0_grant, r1_grant, eng_start, eng_wr, r0_done, r0_err, r0_rd_en} !== 7'b0 || eng_addr !== 32'h0 || r0_rd_data !== 16'h0) begin
            fails++;
            $display("FAIL rst_async: seen=%0b ctrl=%b addr=%h rd=%h, required all 0", seen, {r0_grant, r1_grant, eng_start, eng_wr, r0_done, r0_err, r0_rd_en}, eng_addr, r0_rd_data);
        end
        bad = 0;
        repeat (3) begin
            @(negedge sys_clk);
            if (r0_done || r1_done) bad++;
        end
        eng_rd_en = 1'b0; r0_wr = 1'b0;
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        if (r0_done || r1_done) bad++;
        tests++;
        if (bad !== 0) begin
            fails++;
            $display("FAIL rst_no_done: %0d done pulses, required 0", bad);
        end
        r0_req = 1'b1; r1_req = 1'b1;
        do_op(2, to, owner, addr, wr, lat, dm, em);
        r0_req = 1'b0; r1_req = 1'b0;
        tests++;
        if (to || owner !== 0 || addr !== 32'h10 || dm !== 2'b01) begin
            fails++;
            $display("FAIL rst_rr: to=%0b owner=%0d addr=%h done=%b, required owner 0", to, owner, addr, dm);
        end
    endtask

    task automatic test_random();
        int model_last = 1;
        int exp_owner, exp_lat, owner, lat, k;
        bit exp_err, to;
        logic [1:0] pat;
        logic [31:0] a0, a1, addr;
        logic w0, w1, wr;
        logic [1:0] dm, em;
        apply_reset();
        for (int n = 0; n < 16; n++) begin
            pat = 2'($urandom_range(1, 3));
            a0 = $urandom; a1 = $urandom;
            w0 = 1'($urandom_range(0, 1)); w1 = 1'($urandom_range(0, 1));
            k = ($urandom_range(0, 3) == 0) ? $urandom_range(995, 1003) : $urandom_range(0, 30);
            r0_req = pat[0]; r1_req = pat[1]; r0_addr = a0; r1_addr = a1; r0_wr = w0; r1_wr = w1;
            exp_owner = (pat == 2'b11) ? (model_last == 1 ? 0 : 1) : (pat[1] ? 1 : 0);
            exp_lat = (k < 1000) ? k + 1 : 1000;
            exp_err = (k >= 1000);
            do_op(k, to, owner, addr, wr, lat, dm, em);
            r0_req = 1'b0; r1_req = 1'b0;
            tests++;
            if (to || owner !== exp_owner || addr !== (exp_owner == 1 ? a1 : a0) || wr !== (exp_owner == 1 ? w1 : w0)) begin
                fails++;
                $display("FAIL rand_grant%0d: to=%0b owner=%0d addr=%h wr=%0b, required owner %0d", n, to, owner, addr, wr, exp_owner);
            end
            tests++;
            if (lat !== exp_lat || dm !== (exp_owner == 1 ? 2'b10 : 2'b01) || em !== (exp_err ? dm : 2'b00)) begin
                fails++;
                $display("FAIL rand_resp%0d: lat=%0d done=%b err=%b, required lat %0d err %0b", n, lat, dm, em, exp_lat, exp_err);
            end
            model_last = exp_owner;
        end
    endtask

    initial begin
        test_reset();
        test_init_gate();
        test_round_robin();
        test_timeout();
        test_done_vs_timeout();
        test_routing();
        test_reset_mid_run();
        test_random();
        repeat (2) @(negedge sys_clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sd_access_arbiter.md
SD_ACCESS_ARBITER -- requirements
Module: sd_access_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, sector address width.
REQ-002 SHALL have parameter DATA_W, default 16, engine data word width.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 24'd10_000_000, maximum cycles one sector operation may take.
REQ-004 SHALL have port sys_clk  in  1  sole clock, 50 MHz.
REQ-005 SHALL have port sys_rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port init_end  in  1  SD engine initialisation complete (level).
REQ-007 SHALL have ports rN_req  in  1  sector operation request, N in {0,1}.
REQ-008 SHALL have ports rN_wr  in  1  1 = write sector, 0 = read sector.
REQ-009 SHALL have ports rN_addr  in  ADDR_W  sector address.
REQ-010 SHALL have ports rN_grant  out  1  requester N owns the engine.
REQ-011 SHALL have ports rN_done  out  1  one-cycle completion pulse.
REQ-012 SHALL have ports rN_err  out  1  valid with rN_done, 1 = timeout.
REQ-013 SHALL have ports rN_wr_data  in  DATA_W, rN_wr_req  out  1, rN_rd_en  out  1, rN_rd_data  out  DATA_W  per-requester data path.
REQ-014 SHALL have ports eng_start  out  1, eng_wr  out  1, eng_addr  out  ADDR_W  engine command.
REQ-015 SHALL have ports eng_busy  in  1, eng_done  in  1  engine status; eng_done is a one-cycle pulse.
REQ-016 SHALL have ports eng_wr_data  out  DATA_W, eng_wr_req  in  1, eng_rd_en  in  1, eng_rd_data  in  DATA_W  engine data path.

Function
REQ-017 SHALL implement FSM states IDLE, START, RUN, RESP; all control outputs registered.
REQ-018 SHALL, in IDLE, grant only when init_end=1 and eng_busy=0 and at least one rN_req=1; otherwise remain in IDLE.
REQ-019 SHALL arbitrate round-robin: single request wins; both requesting -> requester not served last wins; last-served register updated in RESP.
REQ-020 SHALL, on the grant edge, latch winner's rN_wr/rN_addr into eng_wr/eng_addr, set rN_grant=1, enter START; grant visible cycle T+1 for request sampled at cycle T.
REQ-021 SHALL assert eng_start for exactly one cycle (state START), then enter RUN.
REQ-022 SHALL hold eng_wr, eng_addr, rN_grant stable from START until leaving RESP.
REQ-023 SHALL, in RUN, count cycles with a timer cleared on entry; eng_done=1 -> RESP with err=0; timer reaching TIMEOUT_CYC-1 without eng_done -> RESP with err=1.
REQ-024 SHALL give eng_done priority over timeout when both occur in the same cycle (err=0).
REQ-025 SHALL, in RESP, pulse owner's rN_done one cycle with rN_err, clear rN_grant at end of RESP, return to IDLE.
REQ-026 SHALL ignore eng_done outside RUN, and ignore rN_req deassertion after grant (operation completes).
REQ-027 SHALL sample requests again only in IDLE; earliest re-grant is two cycles after rN_done (RESP->IDLE->START).
REQ-028 SHALL ignore init_end falling during START/RUN/RESP; gating applies only in IDLE.
REQ-029 SHALL route combinationally by owner: eng_wr_data = owner's rN_wr_data; eng_wr_req -> owner's rN_wr_req; eng_rd_en/eng_rd_data -> owner's rN_rd_en/rN_rd_data; non-owner and no-owner outputs = 0; eng_wr_data = 0 with no owner.
REQ-030 SHALL never assert both r0_grant and r1_grant.

Reset
REQ-031 SHALL, on sys_rst_n=0, immediately force state IDLE, all rN_grant/rN_done/rN_err/eng_start/eng_wr = 0, eng_addr = 0, timer = 0, last-served = 1 (r0 wins first tie).
REQ-032 SHALL abort any operation in progress on reset without issuing rN_done.

Verification
REQ-033 SHALL cover: init_end=0, r0_req=1 for 100 cycles -> no grant, eng_start=0; init_end->1 -> r0_grant next cycle, one eng_start pulse.
REQ-034 SHALL cover: r0_req and r1_req both 1 after reset, eng_done 50 cycles after each start -> grant order r0, r1, r0, r1; addresses 0x10/0x20 appear on eng_addr matching owner.
REQ-035 SHALL cover: r1 write 0x0000_0400, engine never asserts eng_done, TIMEOUT_CYC=1000 -> r1_done and r1_err=1 exactly 1000 cycles after RUN entry.
REQ-036 SHALL cover: eng_done and timeout same cycle -> rN_err=0; stray eng_done in IDLE -> no rN_done.
REQ-037 SHALL cover: r0 owner, eng_rd_en=1, eng_rd_data=0xA55A -> r0_rd_data=0xA55A, r1_rd_data=0, r1_rd_en=0.
REQ-038 SHALL cover: sys_rst_n low mid-RUN -> all outputs 0 asynchronously, no rN_done; after release r0 wins a simultaneous request.
